// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels, default frame shape.
// Latency: none (types and constants only).
// Backpressure: not applicable; used by txd_ctrl, txd_clk and the future receiver.
package uart_pkg;

    // Transmit controller states, in frame order.
    typedef enum logic [2:0] {
        TXD_IDLE   = 3'd0,
        TXD_START  = 3'd1,
        TXD_DATA   = 3'd2,
        TXD_PARITY = 3'd3,
        TXD_STOP   = 3'd4
    } txd_state_t;

    // Line levels: the line rests at mark, a frame opens with a space.
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // Default frame shape, 8 data bits and 1 stop bit.
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/txd_ctrl.sv
// UART transmit FSM: byte in over valid/ready, start/data/[parity]/stop out on txd; parity with TXD_PARITY_EN.
// Latency: txd falls and tx_start pulses one cycle after accept; each bit changes one cycle after its bps_clk pulse.
// Backpressure: tx_ready is low for the whole frame and for the tx_done cycle, so frames are spaced by one idle cycle.
module txd_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int STOP_BITS  = UART_STOP_BITS,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       bps_clk,
    output logic       tx_start,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       txd
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    txd_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       txd_q, txd_d;
    logic       tx_start_q, tx_start_d;
    logic       tx_done_q, tx_done_d;
    logic       tx_busy_q, tx_busy_d;
    logic       accept;

`ifdef TXD_PARITY_EN
    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
    logic       parity_q, parity_d;
`else
    logic       unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    // Holding ready low on the tx_done cycle keeps tx_start and tx_done apart.
    assign tx_ready = (state_q == TXD_IDLE) && !tx_done_q;
    assign accept   = tx_valid && tx_ready;

    // Next-state, shift register, counters and registered line outputs.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        tx_start_d = 1'b0;
        tx_done_d  = 1'b0;
        tx_busy_d  = tx_busy_q;
`ifdef TXD_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            TXD_IDLE: begin
                if (accept) begin
                    shift_d    = tx_data;
`ifdef TXD_PARITY_EN
                    parity_d   = (^(tx_data & DATA_MASK)) ^ (PARITY_ODD != 0);
`endif
                    txd_d      = UART_START_LVL;
                    tx_start_d = 1'b1;
                    tx_busy_d  = 1'b1;
                    state_d    = TXD_START;
                end
            end
            TXD_START: begin
                if (bps_clk) begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = TXD_DATA;
                end
            end
            TXD_DATA: begin
                if (bps_clk) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef TXD_PARITY_EN
                        txd_d      = parity_q;
                        state_d    = TXD_PARITY;
`else
                        txd_d      = UART_IDLE_LVL;
                        stop_cnt_d = 1'b0;
                        state_d    = TXD_STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            TXD_PARITY: begin
                if (bps_clk) begin
                    txd_d      = UART_IDLE_LVL;
                    stop_cnt_d = 1'b0;
                    state_d    = TXD_STOP;
                end
            end
            TXD_STOP: begin
                if (bps_clk) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        tx_done_d = 1'b1;
                        tx_busy_d = 1'b0;
                        state_d   = TXD_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                txd_d     = UART_IDLE_LVL;
                tx_busy_d = 1'b0;
                state_d   = TXD_IDLE;
            end
        endcase
    end

    // State register; reset abandons any frame in flight without a tx_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TXD_IDLE;
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            txd_q      <= UART_IDLE_LVL;
            tx_start_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
`ifdef TXD_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            tx_start_q <= tx_start_d;
            tx_done_q  <= tx_done_d;
            tx_busy_q  <= tx_busy_d;
`ifdef TXD_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign txd      = txd_q;
    assign tx_start = tx_start_q;
    assign tx_done  = tx_done_q;
    assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_txd_ctrl.sv
// Bench for txd_ctrl: unit 0 is 8 data/1 stop/even, unit 1 is 5 data/2 stop/odd.
// Frame expectations are hand-written txd sequences indexed by bps_clk pulse number.
// TXD_PARITY_EN selects the parity variant of the vector tables.
module tb_txd_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] tx_valid;
    logic [7:0] tx_data [2];
    logic [1:0] bps_clk;
    logic [1:0] tx_ready;
    logic [1:0] tx_start;
    logic [1:0] tx_done;
    logic [1:0] tx_busy;
    logic [1:0] txd;

    int checks;
    int errors;

    // seq[i] = txd after pulse i (seq[0] = start bit after accept); pulses = frame length.
    typedef struct {
        int          u;
        logic [7:0]  data;
        logic [11:0] seq;
        int          pulses;
        bit          keep;
        logic [7:0]  nxt;
    } vec_t;

    vec_t vecs [7];
    logic [11:0] seq_3c;

    txd_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_data(tx_data[0]), .bps_clk(bps_clk[0]), .tx_start(tx_start[0]),
        .tx_done(tx_done[0]), .tx_busy(tx_busy[0]), .txd(txd[0])
    );

    txd_ctrl #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_data(tx_data[1]), .bps_clk(bps_clk[1]), .tx_start(tx_start[1]),
        .tx_done(tx_done[1]), .tx_busy(tx_busy[1]), .txd(txd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Offer a byte, then pace the frame with bps_clk every 16 cycles and check every bit.
    task automatic run_frame(input string nm, input int u, input logic [7:0] d,
                             input logic [11:0] seq, input int pulses,
                             input bit keep, input logic [7:0] nxt);
        int  guard;
        bit  noisy;
        tx_data[u]  = d;
        tx_valid[u] = 1'b1;
        guard = 0;
        while (!tx_ready[u] && guard < 100) begin
            step();
            guard++;
        end
        chk({nm, "_ready_wait"}, (guard < 100), 1);
        step();
        if (keep) tx_data[u] = nxt;
        else begin
            tx_valid[u] = 1'b0;
            tx_data[u]  = ~d;
        end
        chk({nm, "_start_bit"}, txd[u], seq[0]);
        chk({nm, "_start_pulse"}, tx_start[u], 1);
        chk({nm, "_busy"}, tx_busy[u], 1);
        for (int p = 1; p <= pulses; p++) begin
            noisy = 1'b0;
            for (int c = 0; c < 15; c++) begin
                step();
                if (tx_start[u] || tx_done[u] || tx_ready[u] || txd[u] !== seq[p-1]) noisy = 1'b1;
            end
            chk($sformatf("%s_gap%0d", nm, p), noisy, 0);
            bps_clk[u] = 1'b1;
            step();
            bps_clk[u] = 1'b0;
            chk($sformatf("%s_bit%0d", nm, p), txd[u], seq[p]);
            if (p == pulses) begin
                chk({nm, "_done"}, tx_done[u], 1);
                chk({nm, "_done_busy"}, tx_busy[u], 0);
                chk({nm, "_done_ready"}, tx_ready[u], 0);
                chk({nm, "_done_nostart"}, tx_start[u], 0);
            end else begin
                chk($sformatf("%s_nodone%0d", nm, p), tx_done[u], 0);
            end
        end
        step();
        chk({nm, "_done_width"}, tx_done[u], 0);
        chk({nm, "_ready_after"}, tx_ready[u], 1);
    endtask

    initial begin
        bit noisy;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        tx_valid = 2'b00;
        bps_clk = 2'b00;
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;

`ifdef TXD_PARITY_EN
        // 8E1 frames: start, data LSB-first, parity, stop, idle.
        vecs[0] = '{0, 8'hA5, {2'b11, 1'b0, 8'hA5, 1'b0}, 11, 1'b0, 8'h00};
        vecs[1] = '{0, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 8'h00};
        vecs[2] = '{0, 8'h00, {2'b11, 1'b0, 8'h00, 1'b0}, 11, 1'b0, 8'h00};
        vecs[3] = '{0, 8'h55, {2'b11, 1'b0, 8'h55, 1'b0}, 11, 1'b1, 8'hAA};
        vecs[4] = '{0, 8'hAA, {2'b11, 1'b0, 8'hAA, 1'b0}, 11, 1'b0, 8'h00};
        // 5O2 frames: 0x03 has two ones -> odd parity 1; 0xE9 low bits 01001 -> 1.
        vecs[5] = '{1, 8'h03, {2'b00, 3'b111, 1'b1, 5'b00011, 1'b0}, 9, 1'b0, 8'h00};
        vecs[6] = '{1, 8'hE9, {2'b00, 3'b111, 1'b1, 5'b01001, 1'b0}, 9, 1'b0, 8'h00};
        seq_3c  = {2'b11, 1'b0, 8'h3C, 1'b0};
`else
        // 8N1 frames: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 then idle.
        vecs[0] = '{0, 8'hA5, 12'b0111_0100_1010, 10, 1'b0, 8'h00};
        vecs[1] = '{0, 8'hFF, 12'b0111_1111_1110, 10, 1'b0, 8'h00};
        vecs[2] = '{0, 8'h00, 12'b0110_0000_0000, 10, 1'b0, 8'h00};
        vecs[3] = '{0, 8'h55, 12'b0110_1010_1010, 10, 1'b1, 8'hAA};
        vecs[4] = '{0, 8'hAA, 12'b0111_0101_0100, 10, 1'b0, 8'h00};
        // 5N2 frames: 0x1F -> 0,1,1,1,1,1,1,1; 0xE9 uses only its low bits 01001.
        vecs[5] = '{1, 8'h1F, 12'b0001_1111_1110, 8, 1'b0, 8'h00};
        vecs[6] = '{1, 8'hE9, 12'b0001_1101_0010, 8, 1'b0, 8'h00};
        seq_3c  = 12'b0110_0111_1000;
`endif

        // Reset held for three cycles.
        repeat (3) step();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst_txd%0d", u), txd[u], 1);
            chk($sformatf("rst_ready%0d", u), tx_ready[u], 1);
            chk($sformatf("rst_busy%0d", u), tx_busy[u], 0);
            chk($sformatf("rst_start%0d", u), tx_start[u], 0);
            chk($sformatf("rst_done%0d", u), tx_done[u], 0);
        end
        rst = 1'b0;
        step();

        // bps_clk while idle must not start anything.
        noisy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bps_clk[0] = 1'b1;
            step();
            bps_clk[0] = 1'b0;
            step();
            if (txd[0] !== 1'b1 || tx_busy[0] || tx_start[0] || tx_done[0]) noisy = 1'b1;
        end
        chk("idle_bps_ignored", noisy, 0);

        // Vector table; entries 3/4 run back-to-back with tx_valid held high.
        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].u, vecs[i].data, vecs[i].seq,
                      vecs[i].pulses, vecs[i].keep, vecs[i].nxt);
        end

        // Mid-frame reset after the 4th pulse, then a clean 0x3C frame.
        step();
        tx_data[0]  = 8'h3C;
        tx_valid[0] = 1'b1;
        chk("mr_ready", tx_ready[0], 1);
        step();
        tx_valid[0] = 1'b0;
        chk("mr_start_bit", txd[0], 0);
        for (int p = 1; p <= 4; p++) begin
            repeat (15) step();
            bps_clk[0] = 1'b1;
            step();
            bps_clk[0] = 1'b0;
            chk($sformatf("mr_bit%0d", p), txd[0], seq_3c[p]);
        end
        rst = 1'b1;
        step();
        chk("mr_txd_idle", txd[0], 1);
        chk("mr_busy", tx_busy[0], 0);
        chk("mr_no_done", tx_done[0], 0);
        rst = 1'b0;
        step();
        chk("mr_ready_after", tx_ready[0], 1);
        noisy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bps_clk[0] = 1'b1;
            step();
            bps_clk[0] = 1'b0;
            step();
            if (tx_done[0] || tx_busy[0] || txd[0] !== 1'b1) noisy = 1'b1;
        end
        chk("mr_quiet_after", noisy, 0);
        run_frame("post_rst_3c", 0, 8'h3C, seq_3c, vecs[0].pulses, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/txd_ctrl.md
# txd_ctrl

UART transmit controller: accepts a parallel byte over a valid/ready handshake and serialises it on `txd` as start bit, data LSB-first, optional parity, and stop bit(s). Sits directly upstream of the `txd_clk` baud generator. It drives `txd_clk`'s `tx_start`/`tx_done` inputs, and consumes the `bps_clk` bit-boundary pulses that `txd_clk` produces.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal values 5–8.
- `STOP_BITS`, default 1: stop bits; legal values 1 or 2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Used only when `TXD_PARITY_EN` is defined.
- `clk`  in  1: system clock; everything is on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `tx_valid`  in  1: a byte is offered.
- `tx_ready`  out  1: the block can accept a byte.
- `tx_data`  in  8: payload; bits `[DATA_BITS-1:0]` are used.
- `bps_clk`  in  1: one-`clk`-wide pulse from `txd_clk`, one per bit period.
- `tx_start`  out  1: one-cycle pulse telling `txd_clk` to start bit timing.
- `tx_done`  out  1: one-cycle pulse after the last stop bit; also feeds `txd_clk`.
- `tx_busy`  out  1: high while a frame is on the line.
- `txd`  out  1: serial line; idles high.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Accept:** a byte is accepted when `tx_valid && tx_ready`.
  - `tx_ready = (state==IDLE) && !tx_done`. This leaves a one-cycle gap after every frame, so `tx_start` and `tx_done` are never high in the same cycle.
- **On accept (next edge):**
  - `tx_data` latches into the shift register.
  - Parity latches: XOR-reduce of the data bits, inverted if `PARITY_ODD`.
  - `txd` = 0, `tx_start` = 1 for one cycle, `tx_busy` = 1, state = START.
- **State advance:** states advance only on a cycle where `bps_clk`=1.
  - START → DATA: `txd` = data[0], bit counter = 0.
  - DATA: shift right and `txd` = next bit. When the counter reaches `DATA_BITS-1`, go to PARITY if it is compiled in, otherwise to STOP with `txd`=1.
  - PARITY → STOP: `txd` = 1.
  - STOP: count `STOP_BITS` pulses. The final pulse moves to IDLE with `tx_done` = 1 for one cycle and `tx_busy` = 0.
- **`bps_clk` in IDLE:** ignored.
- **`tx_valid` during a frame:** ignored. `tx_data` may change freely after accept.
- **Reset mid-frame:** at the next edge, `txd`=1 and the state returns to IDLE. No `tx_done` is issued.
- **Bit counter:** 3-bit, never wraps past `DATA_BITS-1`. The stop counter is 1 bit.

## Timing
- **Reset values:** `txd`=1, `tx_ready`=1 (combinational), `tx_start`=0, `tx_done`=0, `tx_busy`=0.
- **All outputs except `tx_ready` are registered.**
- **Start-bit latency:** `txd` falls one cycle after the accept edge, in the same cycle that `tx_start` is high.
- **Bit boundaries:** each bit boundary occurs one cycle after the corresponding `bps_clk` pulse.
- **Frame length:** 1 + `DATA_BITS` + P + `STOP_BITS` `bps_clk` pulses, where P = 1 with parity and 0 without.
- **`tx_done` timing:** high for exactly one cycle, one cycle after the final stop `bps_clk` pulse.
- **Back-to-back frames:** the earliest next accept is the cycle after `tx_done`.

## Configuration
- **Macro:** `TXD_PARITY_EN`.
- **Defined:** the PARITY state is present; the parity bit follows the data and is computed per `PARITY_ODD`.
- **Undefined:** the PARITY state and parity logic are removed, and DATA goes straight to STOP.

## Structure
- **Package `uart_pkg`:**
  - State enum `txd_state_t`.
  - Constants `UART_IDLE_LVL`=1, `UART_START_LVL`=0.
  - Default `DATA_BITS` and `STOP_BITS`; shared with `txd_clk` and the future receiver.
- **No sub-module.** Parity is an inline reduction XOR, and the shift register and counters live in the single FSM module. `txd_clk` is instantiated alongside `txd_ctrl` at the `uart_tx` top, not inside it.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles → `txd`=1, `tx_ready`=1, `tx_busy`=0, `tx_start`=0, `tx_done`=0.
- **Single frame, no parity:** send 0xA5, 8N1, bench model pulses `bps_clk` every 16 clks → `txd` sequence 0,1,0,1,0,0,1,0,1,1; one `tx_start` pulse; `tx_done` one cycle after the 10th pulse.
- **Parity (`TXD_PARITY_EN`):** 0x07 with `PARITY_ODD`=0 → parity bit 1; 0x03 with `PARITY_ODD`=1 → parity bit 1; 0x00 with even parity → parity bit 0.
- **Back-to-back:** hold `tx_valid` high with 0x55 then 0xAA → `tx_ready` is low on the `tx_done` cycle; the second accept happens one cycle later; no `tx_start`/`tx_done` overlap.
- **Stop bits and width:** `STOP_BITS`=2, `DATA_BITS`=5, send 0x1F → `txd` 0,1,1,1,1,1,1,1 and exactly 8 pulses to `tx_done`.
- **Mid-frame reset:** assert `rst` after the 4th `bps_clk` → `txd`=1 at the next edge, no `tx_done`, `tx_ready`=1 after `rst` drops; a following frame of 0x3C transmits correctly.
